// File: rtl/iob_sram_responder_pkg.sv
// Shared definitions for the SRAM responder: FSM encoding, bus widths and field offsets.
// Request layout is {valid, address, wdata, wstrb}; response layout is {rdata, ready}.
package iob_sram_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Wide enough for the full 0..15 wait-state range
   localparam int CNT_W = 4;

   localparam int RESP_READY_BIT = 0;
   localparam int RESP_RDATA_LSB = 1;

   function automatic int req_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   function automatic int resp_w(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int req_wdata_lsb(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int req_addr_lsb(input int data_w);
      return data_w + data_w / 8;
   endfunction

   function automatic int req_valid_bit(input int addr_w, input int data_w);
      return addr_w + data_w + data_w / 8;
   endfunction

endpackage

// File: rtl/iob_sram_responder_if.sv
// Native memory bus between a requester (master) and the SRAM responder (slave).
interface iob_sram_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   import iob_sram_responder_pkg::*;

   localparam int REQ_W  = req_w(ADDR_W, DATA_W);
   localparam int RESP_W = resp_w(DATA_W);

   logic [REQ_W-1:0]  req;
   logic [RESP_W-1:0] resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);

endinterface

// File: rtl/iob_sram_responder_sp_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// The read register only loads on a read access, so writes leave it untouched.
module iob_sp_ram_be #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [DATA_W/8-1:0] we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   din,
   output logic [DATA_W-1:0]   dout
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Array contents deliberately have no reset
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (we[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
      end else if (en && (we == '0)) begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/iob_sram_responder.sv
// SRAM responder on the native bus: access on the accept edge, ready WAIT_STATES+1 cycles later.
// Requests are taken only in IDLE; valid is ignored while a transaction is in flight.
module iob_sram_responder
   import iob_sram_responder_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_ADDR_W  = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   iob_sram_responder_if.slave  bus
);

   localparam int STRB_W    = DATA_W / 8;
   localparam int VALID_BIT = req_valid_bit(ADDR_W, DATA_W);
   localparam int ADDR_LSB  = req_addr_lsb(DATA_W);
   localparam int WDATA_LSB = req_wdata_lsb(DATA_W);

   logic                  valid;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [STRB_W-1:0]     wstrb;
   logic [MEM_ADDR_W-1:0] word_idx;
   logic                  unused_addr_bits;

   assign valid    = bus.req[VALID_BIT];
   assign addr     = bus.req[ADDR_LSB +: ADDR_W];
   assign wdata    = bus.req[WDATA_LSB +: DATA_W];
   assign wstrb    = bus.req[0 +: STRB_W];
   // Byte offset and high address bits alias onto the same word
   assign word_idx = addr[MEM_ADDR_W+1:2];
   assign unused_addr_bits = ^addr;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               ready_q;
   logic               is_read_q;
   logic [DATA_W-1:0]  rdata_hold;
   logic [DATA_W-1:0]  ram_dout;
   logic [DATA_W-1:0]  rdata;
   logic               accept;

   assign accept = (state == IDLE) && valid && !rst;

   iob_sp_ram_be #(
      .DATA_W (DATA_W),
      .ADDR_W (MEM_ADDR_W)
   ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .we   (wstrb),
      .addr (word_idx),
      .din  (wdata),
      .dout (ram_dout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ready_q   <= 1'b0;
         is_read_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  cnt       <= CNT_W'(WAIT_STATES);
                  is_read_q <= (wstrb == '0);
                  if (WAIT_STATES > 0) begin
                     state   <= WAIT;
                     ready_q <= 1'b0;
                  end else begin
                     state   <= RESP;
                     ready_q <= 1'b1;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state   <= RESP;
                  ready_q <= 1'b1;
               end
            end
            RESP: begin
               state   <= IDLE;
               ready_q <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // The RAM read register moves on the accept edge; hold the previous read until this one completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_hold <= '0;
      end else if (ready_q && is_read_q) begin
         rdata_hold <= ram_dout;
      end
   end

   assign rdata    = (ready_q && is_read_q) ? ram_dout : rdata_hold;
   assign bus.resp = {rdata, ready_q};

endmodule

// File: tb/tb_iob_sram_responder.sv
// Directed bench for iob_sram_responder with 0, 3 and 5 wait states.
module tb_iob_sram_responder;
   import iob_sram_responder_pkg::*;

   localparam int RQW = 1 + 32 + 32 + 4;
   localparam int RSW = 33;

   logic clk = 1'b0;
   logic rst;
   logic rst5;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   iob_sram_responder_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
   iob_sram_responder_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();
   iob_sram_responder_if #(.ADDR_W(32), .DATA_W(32)) bus5 ();

   iob_sram_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(12), .WAIT_STATES(0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   iob_sram_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(12), .WAIT_STATES(3))
      dut3 (.clk(clk), .rst(rst), .bus(bus3));
   iob_sram_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(12), .WAIT_STATES(5))
      dut5 (.clk(clk), .rst(rst5), .bus(bus5));

   function automatic logic [RQW-1:0] mk(input logic v, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
      return {v, a, d, s};
   endfunction

   task automatic drive(input int d, input logic [RQW-1:0] r);
      case (d)
         0:       bus0.req = r;
         3:       bus3.req = r;
         default: bus5.req = r;
      endcase
   endtask

   function automatic logic [RSW-1:0] resp_of(input int d);
      case (d)
         0:       return bus0.resp;
         3:       return bus3.resp;
         default: return bus5.resp;
      endcase
   endfunction

   // One transaction: lat counts cycles from accept edge to the ready cycle (0 = never seen)
   task automatic txn(input int d, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, output int lat, output logic [31:0] rd,
                      output logic [31:0] rd_pre, output logic rdy_next);
      logic [RSW-1:0] r;
      lat = 0; rd = '0; rd_pre = '0; rdy_next = 1'b1;
      @(negedge clk);
      drive(d, mk(1'b1, a, dat, s));
      @(posedge clk);
      #1 drive(d, mk(1'b0, a, dat, s));
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         r = resp_of(d);
         if (c == 1) rd_pre = r[RSW-1:1];
         if (r[0]) begin
            lat = c;
            rd  = r[RSW-1:1];
            break;
         end
      end
      if (lat != 0) begin
         @(negedge clk);
         r = resp_of(d);
         rdy_next = r[0];
      end
   endtask

   task automatic test_reset();
      logic [RSW-1:0] r;
      #2;
      r = resp_of(0);
      checks++; if (r !== '0) begin errors++; $display("FAIL reset_resp0: got %h expected 0", r); end
      r = resp_of(3);
      checks++; if (r !== '0) begin errors++; $display("FAIL reset_resp3: got %h expected 0", r); end
      r = resp_of(5);
      checks++; if (r !== '0) begin errors++; $display("FAIL reset_resp5: got %h expected 0", r); end
      @(negedge clk);
      rst = 1'b0; rst5 = 1'b0;
      repeat (2) @(negedge clk);
      r = resp_of(0);
      checks++; if (r !== '0) begin errors++; $display("FAIL idle_resp0: got %h expected 0", r); end
   endtask

   task automatic test_basic();
      int lat; logic [31:0] rd, pre; logic nx;
      txn(0, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, pre, nx);
      checks++; if (lat !== 1) begin errors++; $display("FAIL basic_wr_lat: got %0d expected 1", lat); end
      checks++; if (nx !== 1'b0) begin errors++; $display("FAIL basic_wr_width: ready next %b expected 0", nx); end
      txn(0, 32'h10, 32'h0, 4'h0, lat, rd, pre, nx);
      checks++; if (lat !== 1) begin errors++; $display("FAIL basic_rd_lat: got %0d expected 1", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
      checks++; if (nx !== 1'b0) begin errors++; $display("FAIL basic_rd_width: ready next %b expected 0", nx); end
      txn(0, 32'h14, 32'h12345678, 4'hF, lat, rd, pre, nx);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_wr_keeps_rdata: got %h expected deadbeef", rd); end
   endtask

   task automatic test_wait_states();
      int lat; logic [31:0] rd, pre; logic nx;
      txn(3, 32'h20, 32'h55667788, 4'hF, lat, rd, pre, nx);
      checks++; if (lat !== 4) begin errors++; $display("FAIL ws_wr_lat: got %0d expected 4", lat); end
      txn(3, 32'h20, 32'h0, 4'h0, lat, rd, pre, nx);
      checks++; if (lat !== 4) begin errors++; $display("FAIL ws_rd_lat: got %0d expected 4", lat); end
      checks++; if (rd !== 32'h55667788) begin errors++; $display("FAIL ws_rd_data: got %h expected 55667788", rd); end
      checks++; if (nx !== 1'b0) begin errors++; $display("FAIL ws_rd_width: ready next %b expected 0", nx); end
      txn(3, 32'h24, 32'h01020304, 4'hF, lat, rd, pre, nx);
      txn(3, 32'h24, 32'h0, 4'h0, lat, rd, pre, nx);
      checks++; if (pre !== 32'h55667788) begin errors++; $display("FAIL ws_rdata_held: got %h expected 55667788", pre); end
      checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL ws_rd2_data: got %h expected 01020304", rd); end
   endtask

   task automatic test_byte_enables();
      int lat; logic [31:0] rd, pre; logic nx;
      txn(0, 32'h8, 32'h11223344, 4'hF, lat, rd, pre, nx);
      txn(0, 32'h8, 32'hAABBCCDD, 4'h5, lat, rd, pre, nx);
      txn(0, 32'h8, 32'h0, 4'h0, lat, rd, pre, nx);
      checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_strb5: got %h expected 11bb33dd", rd); end
      txn(0, 32'h8, 32'hFFEEDDCC, 4'h8, lat, rd, pre, nx);
      txn(0, 32'h8, 32'h0, 4'h0, lat, rd, pre, nx);
      checks++; if (rd !== 32'hFFBB33DD) begin errors++; $display("FAIL be_strb8: got %h expected ffbb33dd", rd); end
   endtask

   task automatic test_aliasing();
      int lat; logic [31:0] rd, pre; logic nx;
      txn(0, 32'h0000_4004, 32'hCAFE0001, 4'hF, lat, rd, pre, nx);
      txn(0, 32'h0000_0004, 32'h0, 4'h0, lat, rd, pre, nx);
      checks++; if (rd !== 32'hCAFE0001) begin errors++; $display("FAIL alias_low: got %h expected cafe0001", rd); end
      txn(0, 32'h00FF_4007, 32'h0, 4'h0, lat, rd, pre, nx);
      checks++; if (rd !== 32'hCAFE0001) begin errors++; $display("FAIL alias_high_offset: got %h expected cafe0001", rd); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd, pre; logic nx;
      logic [RSW-1:0] r;
      logic exp_rdy;
      int n = 0;
      int nrdy = 0;
      for (int i = 0; i < 4; i++)
         txn(0, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, lat, rd, pre, nx);
      @(negedge clk);
      drive(0, mk(1'b1, 32'h100, 32'h0, 4'h0));
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         r = resp_of(0);
         exp_rdy = (c <= 7) && (c % 2 == 1);
         checks++; if (r[0] !== exp_rdy) begin errors++; $display("FAIL b2b_ready_c%0d: got %b expected %b", c, r[0], exp_rdy); end
         if (r[0]) begin
            nrdy++;
            checks++; if (r[RSW-1:1] !== 32'hA000_0000 + 32'(n)) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", n, r[RSW-1:1], 32'hA000_0000 + 32'(n)); end
            n++;
            if (n < 4) drive(0, mk(1'b1, 32'h100 + 32'(4*n), 32'h0, 4'h0));
            else       drive(0, mk(1'b0, 32'h0, 32'h0, 4'h0));
         end
      end
      drive(0, mk(1'b0, 32'h0, 32'h0, 4'h0));
      checks++; if (nrdy !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", nrdy); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd, pre; logic nx;
      logic [RSW-1:0] r;
      int nrdy = 0;
      @(negedge clk);
      drive(5, mk(1'b1, 32'h30, 32'h0BADF00D, 4'hF));
      @(posedge clk);
      #1 drive(5, mk(1'b0, 32'h30, 32'h0BADF00D, 4'hF));
      repeat (2) @(negedge clk);
      #1 rst5 = 1'b1;
      #1 r = resp_of(5);
      checks++; if (r !== '0) begin errors++; $display("FAIL rstmid_resp: got %h expected 0", r); end
      repeat (2) @(negedge clk);
      rst5 = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         r = resp_of(5);
         if (r[0]) nrdy++;
      end
      checks++; if (nrdy !== 0) begin errors++; $display("FAIL rstmid_no_ready: got %0d pulses expected 0", nrdy); end
      txn(5, 32'h30, 32'h0, 4'h0, lat, rd, pre, nx);
      checks++; if (lat !== 6) begin errors++; $display("FAIL rstmid_rd_lat: got %0d expected 6", lat); end
      checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_committed: got %h expected 0badf00d", rd); end
   endtask

   initial begin
      rst = 1'b1;
      rst5 = 1'b1;
      bus0.req = '0;
      bus3.req = '0;
      bus5.req = '0;
      test_reset();
      test_basic();
      test_wait_states();
      test_byte_enables();
      test_aliasing();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
